// File: rtl/rv32i_multicycle_control_pkg.sv
// Shared types for the multicycle RV32I control unit: FSM states, opcodes and
// the encodings of every datapath select it drives.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      LUI      = 4'd12,
      AUIPC    = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLTU = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      RES_ALUOUT    = 3'b000,
      RES_MEMDATA   = 3'b001,
      RES_ALURESULT = 3'b010,
      RES_IMMEXT    = 3'b011
   } result_src_t;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_RS1   = 2'b10
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } alu_src_b_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   // Which rule the ALU decoder applies in the current state.
   typedef enum logic [1:0] {
      CLS_ADD    = 2'b00,
      CLS_BRANCH = 2'b01,
      CLS_FUNCT  = 2'b10
   } alu_class_t;

   function automatic imm_src_t imm_src_of(input logic [6:0] op);
      imm_src_t imm;
      case (op)
         OP_LOAD, OP_ITYPE, OP_JALR: imm = IMM_I;
         OP_STORE:                   imm = IMM_S;
         OP_BRANCH:                  imm = IMM_B;
         OP_JAL:                     imm = IMM_J;
         OP_LUI, OP_AUIPC:           imm = IMM_U;
         default:                    imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/rv32i_multicycle_control_if.sv
// Control/datapath boundary: instruction fields and ALU flags towards the
// controller, selects and write enables back to the datapath.
interface rv32i_multicycle_control_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       ALUResultLSB;
   logic [2:0] ResultSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       PCWrite;
   logic       RegWrite;
   logic       AdrSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl;
   logic       PCSrc;
   logic       Jump;

   modport master (
      input  op, funct3, funct7b5, Zero, ALUResultLSB,
      output ResultSrc, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUControl, PCSrc, Jump
   );

   modport slave (
      output op, funct3, funct7b5, Zero, ALUResultLSB,
      input  ResultSrc, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUControl, PCSrc, Jump
   );
endinterface

// File: rtl/rv32i_multicycle_control_alu_decoder.sv
// Maps the state class and instruction fields onto an ALU operation.
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  alu_class_t alu_class,
   input  logic       op_b5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output alu_ctrl_t  alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_class)
         CLS_BRANCH: begin
            // Equality uses sub/Zero; ordered compares read the slt result bit.
            if (!funct3[2])
               alu_control = ALU_SUB;
            else if (!funct3[1])
               alu_control = ALU_SLT;
            else
               alu_control = ALU_SLTU;
         end
         CLS_FUNCT: begin
            case (funct3)
               3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/rv32i_multicycle_control.sv
// Moore-style sequencer of the multicycle RV32I core: one state per micro-step,
// datapath controls decoded from the current state and the held instruction.
module rv32i_multicycle_control
   import rv_ctrl_pkg::*;
(
   input logic                          clk,
   input logic                          reset,
   rv32i_multicycle_control_if.master   bus
);

   state_t      cycle_state;
   state_t      state_next;
   state_t      out_state;
   alu_class_t  alu_class;
   alu_ctrl_t   alu_control;
   result_src_t result_src;
   alu_src_a_t  src_a;
   alu_src_b_t  src_b;
   logic        mem_write;
   logic        ir_write;
   logic        pc_write;
   logic        reg_write;
   logic        adr_src;
   logic        pc_src;
   logic        jump;
   logic        branch_taken;

   always_ff @(posedge clk) begin
      if (!reset)
         cycle_state <= FETCH;
      else
         cycle_state <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      case (cycle_state)
         FETCH:  state_next = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LOAD, OP_STORE: state_next = MEMADR;
               OP_RTYPE:          state_next = EXECUTER;
               OP_ITYPE:          state_next = EXECUTEI;
               OP_BRANCH:         state_next = BRANCH;
               OP_JAL:            state_next = JAL;
               OP_JALR:           state_next = JALR;
               OP_LUI:            state_next = LUI;
               OP_AUIPC:          state_next = AUIPC;
               default:           state_next = FETCH;
            endcase
         end
         MEMADR:   state_next = (bus.op == OP_STORE) ? MEMWRITE : MEMREAD;
         MEMREAD:  state_next = MEMWB;
         EXECUTER: state_next = ALUWB;
         EXECUTEI: state_next = ALUWB;
         JAL:      state_next = ALUWB;
         JALR:     state_next = JAL;
         AUIPC:    state_next = ALUWB;
         default:  state_next = FETCH;
      endcase
   end

   always_comb begin
      branch_taken = 1'b0;
      case (bus.funct3)
         3'b000:         branch_taken = bus.Zero;
         3'b001:         branch_taken = !bus.Zero;
         3'b100, 3'b110: branch_taken = bus.ALUResultLSB;
         3'b101, 3'b111: branch_taken = !bus.ALUResultLSB;
         default:        branch_taken = 1'b0;
      endcase
   end

   // Held in reset the datapath sees FETCH selects; write enables are masked below.
   assign out_state = reset ? cycle_state : FETCH;

   always_comb begin
      result_src = RES_ALUOUT;
      src_a      = SRCA_PC;
      src_b      = SRCB_RS2;
      alu_class  = CLS_ADD;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      adr_src    = 1'b0;
      pc_src     = 1'b0;
      jump       = 1'b0;
      case (out_state)
         FETCH: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            src_b      = SRCB_FOUR;
            result_src = RES_ALURESULT;
         end
         DECODE: begin
            src_a = SRCA_OLDPC;
            src_b = SRCB_IMM;
         end
         MEMADR: begin
            src_a = SRCA_RS1;
            src_b = SRCB_IMM;
         end
         MEMREAD: begin
            adr_src = 1'b1;
         end
         MEMWB: begin
            result_src = RES_MEMDATA;
            reg_write  = 1'b1;
         end
         MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         EXECUTER: begin
            src_a     = SRCA_RS1;
            src_b     = SRCB_RS2;
            alu_class = CLS_FUNCT;
         end
         EXECUTEI: begin
            src_a     = SRCA_RS1;
            src_b     = SRCB_IMM;
            alu_class = CLS_FUNCT;
         end
         ALUWB: begin
            reg_write = 1'b1;
         end
         BRANCH: begin
            src_a     = SRCA_RS1;
            src_b     = SRCB_RS2;
            alu_class = CLS_BRANCH;
            pc_write  = branch_taken;
            pc_src    = branch_taken;
         end
         JAL: begin
            src_a    = SRCA_OLDPC;
            src_b    = SRCB_FOUR;
            pc_write = 1'b1;
            pc_src   = 1'b1;
            jump     = 1'b1;
         end
         JALR: begin
            src_a = SRCA_RS1;
            src_b = SRCB_IMM;
         end
         LUI: begin
            result_src = RES_IMMEXT;
            reg_write  = 1'b1;
         end
         AUIPC: begin
            src_a = SRCA_OLDPC;
            src_b = SRCB_IMM;
         end
         default: ;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_class   (alu_class),
      .op_b5       (bus.op[5]),
      .funct3      (bus.funct3),
      .funct7b5    (bus.funct7b5),
      .alu_control (alu_control)
   );

   assign bus.ResultSrc  = result_src;
   assign bus.ALUSrcA    = src_a;
   assign bus.ALUSrcB    = src_b;
   assign bus.ImmSrc     = imm_src_of(bus.op);
   assign bus.ALUControl = alu_control;
   assign bus.AdrSrc     = adr_src;
   assign bus.PCSrc      = pc_src;
   assign bus.Jump       = jump;
   assign bus.MemWrite   = mem_write & reset;
   assign bus.IRWrite    = ir_write  & reset;
   assign bus.PCWrite    = pc_write  & reset;
   assign bus.RegWrite   = reg_write & reset;

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Drives whole instructions into the control unit and compares every cycle's
// control vector with an instruction-level model of the expected micro-steps.
module tb_rv32i_multicycle_control;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   rv32i_multicycle_control_if bus ();

   rv32i_multicycle_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {ResultSrc, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, PCSrc, Jump}
   logic [20:0] obs;
   assign obs = {bus.ResultSrc, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                 bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                 bus.PCSrc, bus.Jump};

   logic [20:0] exp_q[$];
   logic [2:0]  cur_imm;
   logic [3:0]  alu_tab [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
   logic [6:0]  legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                  7'b0010111};
   logic [6:0]  illegal_ops [4] = '{7'b1111111, 7'b0000000, 7'b0001111, 7'b1110011};

   task automatic check_val(input string tag, input logic [20:0] got, input logic [20:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %06h expected %06h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] imm_of(input logic [6:0] o);
      case (o)
         7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
         7'b0100011:                         return 3'b001;
         7'b1100011:                         return 3'b010;
         7'b1101111:                         return 3'b011;
         7'b0110111, 7'b0010111:             return 3'b100;
         default:                            return 3'b000;
      endcase
   endfunction

   function automatic logic [20:0] vec(input logic [2:0] res, input logic mw, input logic irw,
                                       input logic pcw, input logic rw, input logic adr,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [3:0] alu, input logic pcsrc, input logic jmp);
      return {res, mw, irw, pcw, rw, adr, a, b, cur_imm, alu, pcsrc, jmp};
   endfunction

   // Instruction-level model: list the control vector of every cycle the instruction takes.
   task automatic build_expect(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input logic l);
      logic [3:0] alu_f;
      logic [3:0] alu_b;
      logic       tk;
      cur_imm = imm_of(o);
      alu_f = alu_tab[f3];
      if (f3 == 3'd0 && o == 7'b0110011 && f7) alu_f = 4'd1;
      if (f3 == 3'd5 && f7) alu_f = 4'd9;
      alu_b = !f3[2] ? 4'd1 : (!f3[1] ? 4'd5 : 4'd6);
      case (f3)
         3'd0:       tk = z;
         3'd1:       tk = !z;
         3'd4, 3'd6: tk = l;
         3'd5, 3'd7: tk = !l;
         default:    tk = 1'b0;
      endcase
      exp_q.delete();
      exp_q.push_back(vec(3'b010, 0, 1, 1, 0, 0, 2'b00, 2'b10, 4'd0, 0, 0));
      exp_q.push_back(vec(3'b000, 0, 0, 0, 0, 0, 2'b01, 2'b01, 4'd0, 0, 0));
      case (o)
         7'b0000011: begin
            exp_q.push_back(vec(3'b000, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'd0, 0, 0));
            exp_q.push_back(vec(3'b000, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'd0, 0, 0));
            exp_q.push_back(vec(3'b001, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'd0, 0, 0));
         end
         7'b0100011: begin
            exp_q.push_back(vec(3'b000, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'd0, 0, 0));
            exp_q.push_back(vec(3'b000, 1, 0, 0, 0, 1, 2'b00, 2'b00, 4'd0, 0, 0));
         end
         7'b0110011, 7'b0010011: begin
            exp_q.push_back(vec(3'b000, 0, 0, 0, 0, 0, 2'b10, o[5] ? 2'b00 : 2'b01, alu_f, 0, 0));
            exp_q.push_back(vec(3'b000, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'd0, 0, 0));
         end
         7'b0010111: begin
            exp_q.push_back(vec(3'b000, 0, 0, 0, 0, 0, 2'b01, 2'b01, 4'd0, 0, 0));
            exp_q.push_back(vec(3'b000, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'd0, 0, 0));
         end
         7'b1100011:
            exp_q.push_back(vec(3'b000, 0, 0, tk, 0, 0, 2'b10, 2'b00, alu_b, tk, 0));
         7'b1101111, 7'b1100111: begin
            if (o == 7'b1100111)
               exp_q.push_back(vec(3'b000, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'd0, 0, 0));
            exp_q.push_back(vec(3'b000, 0, 0, 1, 0, 0, 2'b01, 2'b10, 4'd0, 1, 1));
            exp_q.push_back(vec(3'b000, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'd0, 0, 0));
         end
         7'b0110111:
            exp_q.push_back(vec(3'b011, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'd0, 0, 0));
         default: ;
      endcase
   endtask

   // Entered just after the edge that put the DUT in FETCH; leaves it the same way.
   task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input logic l);
      int n;
      bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z; bus.ALUResultLSB = l;
      build_expect(o, f3, f7, z, l);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_val($sformatf("%s op=%b f3=%0d cyc%0d", name, o, f3, i), obs, exp_q[i]);
         @(posedge clk); #1;
      end
      $display("instr %-6s op=%b f3=%0d f7=%0d z=%0d lsb=%0d cycles=%0d", name, o, f3, f7, z, l, n);
   endtask

   function automatic logic [20:0] reset_vec(input logic [6:0] o);
      cur_imm = imm_of(o);
      return vec(3'b010, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'd0, 0, 0);
   endfunction

   initial begin
      logic [6:0] o;
      bus.op = 7'b0110011; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
      bus.Zero = 1'b0; bus.ALUResultLSB = 1'b0;

      // Two cycles in reset: FETCH selects, no writes.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_val($sformatf("reset cyc%0d", i), obs, reset_vec(bus.op));
         @(posedge clk); #1;
      end
      reset = 1'b1;
      $display("reset released");

      run_instr("rsub",  7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0);
      run_instr("lw",    7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0);
      run_instr("sw",    7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0);
      run_instr("bge",   7'b1100011, 3'd5, 1'b0, 1'b0, 1'b0);
      run_instr("bge",   7'b1100011, 3'd5, 1'b0, 1'b0, 1'b1);
      run_instr("jalr",  7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0);
      run_instr("lui",   7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0);
      run_instr("ill",   7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0);
      run_instr("srai",  7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0);
      run_instr("addi",  7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0);

      // Reset asserted mid-instruction (lw sitting in MEMADR) returns to FETCH.
      bus.op = 7'b0000011; bus.funct3 = 3'd2;
      build_expect(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_val($sformatf("mid lw cyc%0d", i), obs, exp_q[i]);
         @(posedge clk); #1;
      end
      reset = 1'b0;
      @(negedge clk);
      check_val("mid reset", obs, reset_vec(bus.op));
      @(posedge clk); #1;
      reset = 1'b1;
      $display("mid-instruction reset applied");

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) == 0)
            o = illegal_ops[$urandom_range(0, 3)];
         else
            o = legal_ops[$urandom_range(0, 8)];
         run_instr("rand", o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
